// File: rtl/dram_access_arbiter_if.sv
`timescale 1ns/1ps
// Bundle of video, CPU and RAM-macro signals around the bitmap DRAM arbiter.
// Latency: none, wires only.
// Backpressure: carried by cpu_req/cpu_ack; video requests are never stalled.
interface dram_access_arbiter_if #(
   parameter int ADDR_W = 15
);
   logic              vid_req;
   logic [ADDR_W-1:0] vid_addr;
   logic [7:0]        vid_data;
   logic              vid_valid;
   logic              vid_overrun;
   logic              vid_ovr_clr;

   logic              cpu_req;
   logic              cpu_we;
   logic              cpu_bitmd;
   logic              cpu_pixa;
   logic [ADDR_W-1:0] cpu_addr;
   logic [7:0]        cpu_wdata;
   logic [7:0]        cpu_rdata;
   logic              cpu_ack;

   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [7:0]        mem_wdata;
   logic [7:0]        mem_rdata;

   logic              busy;

   // Arbiter side
   modport slave (
      input  vid_req, vid_addr, vid_ovr_clr,
      input  cpu_req, cpu_we, cpu_bitmd, cpu_pixa, cpu_addr, cpu_wdata,
      input  mem_rdata,
      output vid_data, vid_valid, vid_overrun,
      output cpu_rdata, cpu_ack,
      output mem_addr, mem_we, mem_wdata,
      output busy
   );

   // Requester / RAM-macro side
   modport master (
      output vid_req, vid_addr, vid_ovr_clr,
      output cpu_req, cpu_we, cpu_bitmd, cpu_pixa, cpu_addr, cpu_wdata,
      output mem_rdata,
      input  vid_data, vid_valid, vid_overrun,
      input  cpu_rdata, cpu_ack,
      input  mem_addr, mem_we, mem_wdata,
      input  busy
   );
endinterface

// File: rtl/dram_access_arbiter.sv
`timescale 1ns/1ps
// Single-port bitmap DRAM sequencer: video fetches (strict priority) vs CPU read / write / nibble pixel RMW.
// Latency: vid_valid and CPU read ack 2 cycles after the read cycle; write/RMW ack 1 cycle after the write cycle.
// Backpressure: CPU holds level cpu_req until cpu_ack; video never stalls, a replaced pending fetch sets sticky overrun.
module dram_access_arbiter #(
   parameter int ADDR_W  = 15,
   parameter bit PIXA_HI = 1'b1
) (
   input  logic                 clk,
   input  logic                 reset,
   dram_access_arbiter_if.slave io_bus
);

   typedef enum logic [2:0] {IDLE, VID_RD, CPU_RD, CPU_WR, RMW_RD, RMW_MRG, RMW_WR} state_t;
   typedef enum logic [1:0] {TAG_NONE, TAG_VID, TAG_CPU} tag_t;

   state_t            r_state, w_state_nxt;
   logic              r_vid_pend;
   logic [ADDR_W-1:0] r_vid_addr;
   logic              r_vid_overrun;
   logic              r_cpu_busy;
   tag_t              r_rd_tag;
   logic [7:0]        r_vid_data;
   logic              r_vid_valid;
   logic [7:0]        r_cpu_rdata;
   logic              r_cpu_ack;
   logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
   logic              r_mem_we, w_mem_we_nxt;
   logic [7:0]        r_mem_wdata, w_mem_wdata_nxt;

   logic              w_vid_any;
   logic [ADDR_W-1:0] w_vid_addr;
   logic              w_vid_take;
   logic              w_cpu_elig;
   logic              w_cpu_grant;
   logic              w_ack_nxt;
   logic [7:0]        w_merged;

   // A request arriving this cycle is granted directly when nothing older is pending,
   // so an idle arbiter fetches on the very next cycle and beats a simultaneous CPU request.
   assign w_vid_any  = r_vid_pend | io_bus.vid_req;
   assign w_vid_addr = r_vid_pend ? r_vid_addr : io_bus.vid_addr;
   // The ack cycle itself is excluded so a held cpu_req is not re-granted on stale inputs.
   assign w_cpu_elig = io_bus.cpu_req & ~r_cpu_busy & ~r_cpu_ack;
   assign w_merged   = (io_bus.cpu_pixa == PIXA_HI) ?
                       {io_bus.cpu_wdata[7:4], io_bus.mem_rdata[3:0]} :
                       {io_bus.mem_rdata[7:4], io_bus.cpu_wdata[3:0]};
   assign w_ack_nxt  = (r_rd_tag == TAG_CPU) | (r_state == CPU_WR) | (r_state == RMW_WR);

   // Next state and the RAM command for the next cycle; grants only from IDLE or a terminal state
   always_comb begin
      w_state_nxt     = r_state;
      w_mem_addr_nxt  = r_mem_addr;
      w_mem_we_nxt    = 1'b0;
      w_mem_wdata_nxt = 8'h00;
      w_cpu_grant     = 1'b0;
      w_vid_take      = 1'b0;
      case (r_state)
         RMW_RD:  w_state_nxt = RMW_MRG;
         RMW_MRG: begin
            w_state_nxt     = RMW_WR;
            w_mem_we_nxt    = 1'b1;
            w_mem_wdata_nxt = w_merged;
         end
         default: begin
            if (w_vid_any) begin
               w_state_nxt    = VID_RD;
               w_mem_addr_nxt = w_vid_addr;
               w_vid_take     = 1'b1;
            end else if (w_cpu_elig) begin
               w_mem_addr_nxt = io_bus.cpu_addr;
               w_cpu_grant    = 1'b1;
               if (!io_bus.cpu_we) begin
                  w_state_nxt = CPU_RD;
               end else if (io_bus.cpu_bitmd) begin
                  w_state_nxt = RMW_RD;
               end else begin
                  w_state_nxt     = CPU_WR;
                  w_mem_we_nxt    = 1'b1;
                  w_mem_wdata_nxt = io_bus.cpu_wdata;
               end
            end else begin
               w_state_nxt = IDLE;
            end
         end
      endcase
   end

   // State register and registered RAM command
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_mem_addr  <= '0;
         r_mem_we    <= 1'b0;
         r_mem_wdata <= 8'h00;
      end else begin
         r_state     <= w_state_nxt;
         r_mem_addr  <= w_mem_addr_nxt;
         r_mem_we    <= w_mem_we_nxt;
         r_mem_wdata <= w_mem_wdata_nxt;
      end
   end

   // Video pending slot: a new request either queues behind the one being granted or replaces an unserved one
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_vid_pend    <= 1'b0;
         r_vid_addr    <= '0;
         r_vid_overrun <= 1'b0;
      end else begin
         if (io_bus.vid_req) begin
            r_vid_addr <= io_bus.vid_addr;
         end
         r_vid_pend <= w_vid_take ? (r_vid_pend & io_bus.vid_req) : (r_vid_pend | io_bus.vid_req);
         if (io_bus.vid_req && r_vid_pend && !w_vid_take) begin
            r_vid_overrun <= 1'b1;
         end else if (io_bus.vid_ovr_clr) begin
            r_vid_overrun <= 1'b0;
         end
      end
   end

   // Read tag, data capture one cycle after the read cycle, and completion pulses
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rd_tag    <= TAG_NONE;
         r_vid_data  <= 8'h00;
         r_vid_valid <= 1'b0;
         r_cpu_rdata <= 8'h00;
         r_cpu_ack   <= 1'b0;
      end else begin
         r_rd_tag <= (r_state == VID_RD) ? TAG_VID :
                     (r_state == CPU_RD) ? TAG_CPU : TAG_NONE;
         r_vid_valid <= (r_rd_tag == TAG_VID);
         if (r_rd_tag == TAG_VID) begin
            r_vid_data <= io_bus.mem_rdata;
         end
         if (r_rd_tag == TAG_CPU) begin
            r_cpu_rdata <= io_bus.mem_rdata;
         end
         r_cpu_ack <= w_ack_nxt;
      end
   end

   // CPU op in flight from grant until its ack is issued
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cpu_busy <= 1'b0;
      end else if (w_cpu_grant) begin
         r_cpu_busy <= 1'b1;
      end else if (w_ack_nxt) begin
         r_cpu_busy <= 1'b0;
      end
   end

   assign io_bus.vid_data    = r_vid_data;
   assign io_bus.vid_valid   = r_vid_valid;
   assign io_bus.vid_overrun = r_vid_overrun;
   assign io_bus.cpu_rdata   = r_cpu_rdata;
   assign io_bus.cpu_ack     = r_cpu_ack;
   assign io_bus.mem_addr    = r_mem_addr;
   assign io_bus.mem_we      = r_mem_we;
   assign io_bus.mem_wdata   = r_mem_wdata;
   assign io_bus.busy        = (r_state != IDLE) | (r_rd_tag != TAG_NONE);

endmodule

// File: tb/tb_dram_access_arbiter.sv
`timescale 1ns/1ps
// Bench for the bitmap DRAM arbiter: synchronous RAM model, reference byte image, response scoreboard.
// Latency: checked directly on the fetch, write, RMW and contention sequences.
// Backpressure: CPU requester holds cpu_req until cpu_ack; video pulses are spaced or overlapped on purpose.
module tb_dram_access_arbiter;
   localparam int ADDR_W  = 15;
   localparam bit PIXA_HI = 1'b1;
   localparam int DEPTH   = 1 << ADDR_W;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   dram_access_arbiter_if #(.ADDR_W(ADDR_W)) bus ();
   dram_access_arbiter #(.ADDR_W(ADDR_W), .PIXA_HI(PIXA_HI)) dut (.clk(clk), .reset(reset), .io_bus(bus));

   // RAM macro: one-cycle synchronous read, unwritten words hold a fixed address pattern
   logic [7:0]        ram [DEPTH];
   bit                ram_vld [DEPTH];
   logic              bd_we   = 1'b0;
   logic [ADDR_W-1:0] bd_addr = '0;
   logic [7:0]        bd_data = 8'h00;

   function automatic logic [7:0] init_val(int a);
      return 8'(a) ^ 8'(a >> 7) ^ 8'h5C;
   endfunction

   always @(posedge clk) begin
      if (bd_we) begin
         ram[bd_addr] <= bd_data;  ram_vld[bd_addr] <= 1'b1;
      end else if (bus.mem_we) begin
         ram[bus.mem_addr] <= bus.mem_wdata;  ram_vld[bus.mem_addr] <= 1'b1;
      end
      bus.mem_rdata <= ram_vld[bus.mem_addr] ? ram[bus.mem_addr] : init_val(int'(bus.mem_addr));
   end

   function automatic logic [7:0] ram_peek(logic [ADDR_W-1:0] a);
      return ram_vld[a] ? ram[a] : init_val(int'(a));
   endfunction

   // Reference model: byte image plus expected responses in completion order
   typedef struct packed { logic rd; logic [7:0] data; } cpu_exp_t;
   logic [7:0] ref_mem [DEPTH];
   cpu_exp_t   cpu_q[$];
   logic [7:0] vid_q[$];
   int n_pass = 0, n_chk = 0, n_ack = 0, n_vvalid = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic logic [7:0] pix_merge(logic [7:0] old, logic [7:0] wd, bit pixa);
      return (pixa == PIXA_HI) ? {wd[7:4], old[3:0]} : {old[7:4], wd[3:0]};
   endfunction

   // Monitor: every completion pulse must match the oldest expectation
   always @(negedge clk) begin
      if (!reset) begin
         if (bus.vid_valid) begin
            n_vvalid++;
            check("vid_valid has queued expectation", 32'(vid_q.size() > 0), 1);
            if (vid_q.size() > 0) check("vid_data", bus.vid_data, vid_q.pop_front());
         end
         if (bus.cpu_ack) begin
            cpu_exp_t e;
            n_ack++;
            check("cpu_ack has queued expectation", 32'(cpu_q.size() > 0), 1);
            if (cpu_q.size() > 0) begin
               e = cpu_q.pop_front();
               if (e.rd) check("cpu_rdata", bus.cpu_rdata, e.data);
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic idle_inputs();
      bus.vid_req = 0; bus.vid_addr = '0; bus.vid_ovr_clr = 0;
      bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_bitmd = 0; bus.cpu_pixa = 0;
      bus.cpu_addr = '0; bus.cpu_wdata = '0;
   endtask

   task automatic bd_write(input logic [ADDR_W-1:0] a, input logic [7:0] d);
      bd_addr = a; bd_data = d; bd_we = 1'b1;
      step(1);
      bd_we = 1'b0;
      ref_mem[a] = d;
   endtask

   task automatic expect_cpu(input bit we, input bit bitmd, input bit pixa,
                             input logic [ADDR_W-1:0] a, input logic [7:0] wd);
      cpu_exp_t e;
      e.rd = !we; e.data = ref_mem[a];
      if (we && bitmd) ref_mem[a] = pix_merge(ref_mem[a], wd, pixa);
      else if (we)     ref_mem[a] = wd;
      cpu_q.push_back(e);
   endtask

   task automatic cpu_drive(input bit we, input bit bitmd, input bit pixa,
                            input logic [ADDR_W-1:0] a, input logic [7:0] wd);
      bus.cpu_we = we; bus.cpu_bitmd = bitmd; bus.cpu_pixa = pixa;
      bus.cpu_addr = a; bus.cpu_wdata = wd; bus.cpu_req = 1'b1;
   endtask

   task automatic wait_ack(input string name);
      bit got = 0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         got = bus.cpu_ack;
      end
      check({name, " ack within bound"}, 32'(got), 1);
   endtask

   task automatic cpu_op(input bit we, input bit bitmd, input bit pixa,
                         input logic [ADDR_W-1:0] a, input logic [7:0] wd);
      expect_cpu(we, bitmd, pixa, a, wd);
      cpu_drive(we, bitmd, pixa, a, wd);
      wait_ack("cpu_op");
      bus.cpu_req = 1'b0;
   endtask

   task automatic vid_pulse(input logic [ADDR_W-1:0] a);
      vid_q.push_back(ref_mem[a]);
      bus.vid_req = 1'b1; bus.vid_addr = a;
      step(1);
      bus.vid_req = 1'b0;
   endtask

   task automatic cpu_random();
      int kind;
      for (int i = 0; i < 40; i++) begin
         kind = int'($urandom_range(2, 0));
         cpu_op(kind != 0, kind == 2, 1'($urandom_range(1, 0)),
                ADDR_W'($urandom_range(32'h0FFF, 0)), 8'($urandom));
         step(int'($urandom_range(3, 1)));
      end
   endtask

   // Video region kept apart from CPU writes so each expected byte is fixed at request time
   task automatic vid_random();
      for (int i = 0; i < 30; i++) begin
         vid_pulse(ADDR_W'($urandom_range(32'h7FFF, 32'h4000)));
         step(int'($urandom_range(10, 5)));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int a0, errs;
      logic [7:0] exp_wd;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
      idle_inputs();
      reset = 1'b1;
      step(3);
      check("reset vid_valid/overrun/cpu_ack/mem_we/busy",
            {bus.vid_valid, bus.vid_overrun, bus.cpu_ack, bus.mem_we, bus.busy}, 0);
      check("reset vid_data/cpu_rdata/mem_wdata", {bus.vid_data, bus.cpu_rdata, bus.mem_wdata}, 0);
      check("reset mem_addr", bus.mem_addr, 0);
      reset = 1'b0;
      step(2);

      // Video fetch latency
      bd_write(15'h1234, 8'hA5);
      vid_pulse(15'h1234);
      check("fetch mem_addr in cycle 1", bus.mem_addr, 15'h1234);
      check("fetch mem_we low in VID_RD", bus.mem_we, 0);
      step(1);
      check("fetch vid_valid not in cycle 2", bus.vid_valid, 0);
      step(1);
      check("fetch vid_valid in cycle 3", bus.vid_valid, 1);
      check("fetch vid_data", bus.vid_data, 8'hA5);
      step(3);

      // High-nibble then low-nibble pixel writes
      bd_write(15'h0400, 8'h3C);
      a0 = n_ack;
      cpu_op(1, 1, PIXA_HI, 15'h0400, 8'hF0);
      step(4);
      check("pixel hi RAM[0x400]", ram_peek(15'h0400), 8'hFC);
      check("pixel hi single ack", n_ack - a0, 1);
      bd_write(15'h0400, 8'h3C);
      cpu_op(1, 1, !PIXA_HI, 15'h0400, 8'h07);
      step(4);
      check("pixel lo RAM[0x400]", ram_peek(15'h0400), 8'h37);

      // Simultaneous video and CPU write: video first, write back-to-back
      vid_q.push_back(ref_mem[15'h1000]);
      expect_cpu(1, 0, 0, 15'h0800, 8'h5A);
      bus.vid_req = 1'b1; bus.vid_addr = 15'h1000;
      cpu_drive(1, 0, 0, 15'h0800, 8'h5A);
      step(1);
      bus.vid_req = 1'b0;
      check("contention first grant video addr", bus.mem_addr, 15'h1000);
      check("contention first grant no write", bus.mem_we, 0);
      step(1);
      check("contention CPU_WR next cycle", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, {1'b1, 15'h0800, 8'h5A});
      step(1);
      check("plain write ack one cycle after write", bus.cpu_ack, 1);
      bus.cpu_req = 1'b0;
      step(4);

      // vid_req during RMW_RD waits for the atomic RMW, then goes straight in
      expect_cpu(1, 1, PIXA_HI, 15'h0500, 8'h9B);
      exp_wd = ref_mem[15'h0500];
      cpu_drive(1, 1, PIXA_HI, 15'h0500, 8'h9B);
      step(1);
      check("RMW_RD address", bus.mem_addr, 15'h0500);
      vid_q.push_back(ref_mem[15'h5100]);
      bus.vid_req = 1'b1; bus.vid_addr = 15'h5100;
      step(1);
      bus.vid_req = 1'b0;
      step(1);
      check("RMW_WR merged write", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, {1'b1, 15'h0500, exp_wd});
      step(1);
      check("VID_RD right after RMW_WR", {bus.mem_we, bus.mem_addr}, {1'b0, 15'h5100});
      check("RMW ack after RMW_WR", bus.cpu_ack, 1);
      bus.cpu_req = 1'b0;
      check("no overrun for single waiting fetch", bus.vid_overrun, 0);
      step(4);

      // Two requests during RMW: second address wins, overrun flagged
      expect_cpu(1, 1, !PIXA_HI, 15'h0510, 8'h64);
      cpu_drive(1, 1, !PIXA_HI, 15'h0510, 8'h64);
      step(1);
      bus.vid_req = 1'b1; bus.vid_addr = 15'h5200;
      step(1);
      vid_q.push_back(ref_mem[15'h5300]);
      bus.vid_addr = 15'h5300;
      step(1);
      bus.vid_req = 1'b0;
      check("overrun set", bus.vid_overrun, 1);
      step(1);
      check("overrun fetches second address", bus.mem_addr, 15'h5300);
      bus.cpu_req = 1'b0;
      step(4);
      check("overrun sticky", bus.vid_overrun, 1);
      bus.vid_ovr_clr = 1'b1;
      step(1);
      bus.vid_ovr_clr = 1'b0;
      check("vid_ovr_clr clears overrun", bus.vid_overrun, 0);

      // Back-to-back reads with cpu_req held through the ack cycles
      bd_write(15'h0700, 8'h11); bd_write(15'h0701, 8'h22); bd_write(15'h0702, 8'h33);
      a0 = n_ack;
      for (int k = 0; k < 3; k++) begin
         expect_cpu(0, 0, 0, ADDR_W'(15'h0700 + k), 8'h00);
         cpu_drive(0, 0, 0, ADDR_W'(15'h0700 + k), 8'h00);
         wait_ack("held read");
      end
      bus.cpu_req = 1'b0;
      step(5);
      check("held reads one ack each", n_ack - a0, 3);

      // Reset in the middle of an RMW abandons it
      check("queues drained before reset test", 32'(vid_q.size() + cpu_q.size()), 0);
      bd_write(15'h0600, 8'h11);
      a0 = n_ack;
      cpu_drive(1, 1, PIXA_HI, 15'h0600, 8'hEE);
      step(2);
      check("in RMW_MRG before reset", {bus.mem_we, bus.mem_addr}, {1'b0, 15'h0600});
      reset = 1'b1;
      #1;
      check("async reset clears mem_* and busy", {bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.busy}, 0);
      bus.cpu_req = 1'b0;
      step(2);
      reset = 1'b0;
      step(5);
      check("abandoned RMW gives no ack", n_ack - a0, 0);
      check("abandoned RMW leaves RAM", ram_peek(15'h0600), 8'h11);

      // Randomised concurrent traffic
      fork
         cpu_random();
         vid_random();
      join
      step(20);
      check("all responses delivered", 32'(vid_q.size() + cpu_q.size()), 0);
      check("no overrun with spaced fetches", bus.vid_overrun, 0);
      errs = 0;
      for (int i = 0; i < DEPTH; i++) if (ram_peek(ADDR_W'(i)) !== ref_mem[i]) errs++;
      check("RAM image vs reference", errs, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
